eth_mac_tx_arbiter: RTL



---
 rtl/eth_mac_tx_arbiter_pkg.sv | 10 +
 rtl/eth_mac_tx_arbiter_if.sv | 37 +++
 rtl/eth_mac_tx_arbiter_rr_select.sv | 26 ++
 rtl/eth_mac_tx_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/eth_mac_tx_arbiter_pkg.sv
// Shared types for the MAC transmit arbiter: FSM state encoding and stall-counter width.
package eth_mac_pkg;
  typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} arb_state_t;

  localparam int STALL_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/eth_mac_tx_arbiter_if.sv
// AXI-stream bundle between PORTS frame sources, the arbiter and the MAC tx_axis input.
interface eth_mac_tx_arbiter_if
  import eth_mac_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = idx_w(PORTS);

  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS-1:0]            s_axis_tvalid;
  logic [PORTS-1:0]            s_axis_tready;
  logic [PORTS-1:0]            s_axis_tlast;
  logic [PORTS-1:0]            s_axis_tuser;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic                        m_axis_tlast;
  logic                        m_axis_tuser;
  logic                        grant_valid;
  logic [IW-1:0]               grant_index;
  logic                        abort_pulse;

  // Arbiter side: consumes the sources, drives the MAC.
  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output grant_valid, grant_index, abort_pulse
  );

  // Environment side: sources plus MAC.
  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  grant_valid, grant_index, abort_pulse
  );
endinterface

// File: rtl/eth_mac_tx_arbiter_rr_select.sv
// Combinational round-robin priority encoder: first set request at or above the pointer, wrapping.
module eth_rr_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);
  int w_j;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = 0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!o_found && i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/eth_mac_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the 1G MAC tx_axis; 1-cycle grant, then combinational pass-through.
// Stalled sources are aborted with a bad-frame beat. ETH_TX_ARB_PRIO0_EN gives port 0 strict priority.
module eth_mac_tx_arbiter
  import eth_mac_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  eth_mac_tx_arbiter_if.master bus
);
  localparam int IW = idx_w(PORTS);
  localparam logic [STALL_W-1:0] TO = STALL_W'(TIMEOUT);

  arb_state_t          r_state;
  logic [IW-1:0]       r_sel;
  logic [IW-1:0]       r_ptr;
  logic [STALL_W-1:0]  r_stall;

  logic [PORTS-1:0]      w_req;
  logic [IW-1:0]         w_rr_idx;
  logic                  w_rr_found;
  logic [IW-1:0]         w_pick;
  logic                  w_found;
  logic                  w_keep_ptr;
  logic [IW-1:0]         w_ptr_adv;
  logic [IW-1:0]         w_ptr_next;
  logic [STALL_W-1:0]    w_stall_inc;
  logic                  w_sel_vld;
  logic                  w_sel_last;
  logic                  w_sel_user;
  logic [DATA_WIDTH-1:0] w_sel_dat;

  assign w_sel_vld   = bus.s_axis_tvalid[r_sel];
  assign w_sel_last  = bus.s_axis_tlast[r_sel];
  assign w_sel_user  = bus.s_axis_tuser[r_sel];
  assign w_sel_dat   = bus.s_axis_tdata[int'(r_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_stall_inc = r_stall + 1'b1;
  assign w_ptr_adv   = (r_sel == IW'(PORTS-1)) ? '0 : r_sel + 1'b1;
  assign w_ptr_next  = w_keep_ptr ? r_ptr : w_ptr_adv;

`ifdef ETH_TX_ARB_PRIO0_EN
  localparam logic [PORTS-1:0] P0_BIT = {{(PORTS-1){1'b0}}, 1'b1};
  // Port 0 bypasses the rotation, so its frames must not move the pointer either.
  assign w_req      = bus.s_axis_tvalid & ~P0_BIT;
  assign w_found    = bus.s_axis_tvalid[0] | w_rr_found;
  assign w_pick     = bus.s_axis_tvalid[0] ? '0 : w_rr_idx;
  assign w_keep_ptr = (r_sel == '0);
`else
  assign w_req      = bus.s_axis_tvalid;
  assign w_found    = w_rr_found;
  assign w_pick     = w_rr_idx;
  assign w_keep_ptr = 1'b0;
`endif

  eth_rr_select #(.N(PORTS), .IW(IW)) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_stall <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_stall <= '0;
          if (w_found) begin
            r_sel   <= w_pick;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_sel_vld) begin
            r_stall <= '0;
            if (bus.m_axis_tready && w_sel_last) begin
              r_ptr   <= w_ptr_next;
              r_state <= IDLE;
            end
          end else if (TIMEOUT != 0 && w_stall_inc == TO) begin
            r_stall <= '0;
            r_state <= ABORT;
          end else begin
            r_stall <= w_stall_inc;
          end
        end
        ABORT: begin
          if (bus.m_axis_tready) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_sel_vld && w_sel_last) begin
            r_ptr   <= w_ptr_next;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data path is combinational from the granted source so PASS adds no latency per beat.
  always_comb begin
    bus.m_axis_tdata  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tuser  = 1'b0;
    bus.s_axis_tready = '0;
    bus.grant_valid   = 1'b0;
    bus.grant_index   = '0;
    bus.abort_pulse   = 1'b0;
    unique case (r_state)
      PASS: begin
        bus.m_axis_tdata         = w_sel_dat;
        bus.m_axis_tvalid        = w_sel_vld;
        bus.m_axis_tlast         = w_sel_last;
        bus.m_axis_tuser         = w_sel_user;
        bus.s_axis_tready[r_sel] = bus.m_axis_tready;
        bus.grant_valid          = 1'b1;
        bus.grant_index          = r_sel;
      end
      ABORT: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tlast  = 1'b1;
        bus.m_axis_tuser  = 1'b1;
        bus.grant_valid   = 1'b1;
        bus.grant_index   = r_sel;
        bus.abort_pulse   = bus.m_axis_tready;
      end
      DRAIN: begin
        bus.s_axis_tready[r_sel] = 1'b1;
        bus.grant_valid          = 1'b1;
        bus.grant_index          = r_sel;
      end
      default: ;
    endcase
  end
endmodule
